// File: rtl/pmem_line_bridge.sv
// ----------------------------------------------------------------------------
// pmem_line_bridge
//
// Physical-memory responder for the L1 caches' 256-bit line interface. Each
// line request turns into one downstream command followed by a fixed burst of
// BEATS beats of BEAT_W bits, lowest-order beat first.
//
// Ports
//   clk, rst_n        clock (rising edge) / asynchronous active-low reset
//   pmem_read         line read request, held until pmem_resp
//   pmem_write        line write request, held until pmem_resp
//   pmem_address      line address, bits [4:0] ignored
//   pmem_wdata        write line, stable while pmem_write is high
//   pmem_resp         one-cycle completion pulse
//   pmem_rdata        last read line, held until the next read completes
//   mem_cmd_valid     downstream command valid
//   mem_cmd_ready     downstream command accept
//   mem_cmd_we        1 = write burst, 0 = read burst
//   mem_cmd_addr      line-aligned command address
//   mem_wvalid        write beat valid
//   mem_wready        write beat accept
//   mem_wdata         write beat data
//   mem_rvalid        read beat valid (no backpressure)
//   mem_rdata         read beat data
//
// BEATS = LINE_W/BEAT_W must be a power of two and at least 2.
// ----------------------------------------------------------------------------
module pmem_line_bridge #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256,
   parameter int BEAT_W = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pmem_read,
   input  logic              pmem_write,
   input  logic [ADDR_W-1:0] pmem_address,
   input  logic [LINE_W-1:0] pmem_wdata,
   output logic              pmem_resp,
   output logic [LINE_W-1:0] pmem_rdata,
   output logic              mem_cmd_valid,
   input  logic              mem_cmd_ready,
   output logic              mem_cmd_we,
   output logic [ADDR_W-1:0] mem_cmd_addr,
   output logic              mem_wvalid,
   input  logic              mem_wready,
   output logic [BEAT_W-1:0] mem_wdata,
   input  logic              mem_rvalid,
   input  logic [BEAT_W-1:0] mem_rdata
);

   localparam int BEATS = LINE_W / BEAT_W;
   localparam int CNT_W = $clog2(BEATS);

   // Clears the five line-offset bits while still reading every address bit.
   localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-5){1'b1}}, 5'b0};

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_WBEAT,
      S_RBEAT,
      S_RESP
   } state_t;

   state_t                       r_state;
   logic [CNT_W-1:0]             r_cnt;
   logic                         r_guard;
   logic                         r_we;
   logic [ADDR_W-1:0]            r_addr;
   logic                         r_cmd_valid;
   logic                         r_wvalid;
   logic [BEAT_W-1:0]            r_wdata;
   logic                         r_resp;
   logic [BEATS-1:0][BEAT_W-1:0] r_line;   // beat 0 occupies bits [BEAT_W-1:0]
   logic [LINE_W-1:0]            r_rdata;

   logic [BEATS-1:0][BEAT_W-1:0] w_line_nxt;
   logic [CNT_W-1:0]             w_cnt_nxt;
   logic                         w_last;

   // Line buffer with the current read beat merged in, so the final beat can
   // be published to pmem_rdata on the same edge that captures it.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would infer a latch.
      w_line_nxt        = r_line;
      w_line_nxt[r_cnt] = mem_rdata;
   end

   assign w_cnt_nxt = r_cnt + 1'b1;   // wraps to 0 after the last beat
   assign w_last    = (r_cnt == CNT_W'(BEATS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the line buffers are plain flops, not a RAM macro, so they
         // can take the asynchronous reset like every other register.
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_guard     <= 1'b0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_cmd_valid <= 1'b0;
         r_wvalid    <= 1'b0;
         r_wdata     <= '0;
         r_resp      <= 1'b0;
         r_line      <= '0;
         r_rdata     <= '0;
      end else begin
         // NOTE: all state uses non-blocking assignments so every register
         // samples the pre-edge values regardless of statement order.
         r_resp  <= 1'b0;
         r_guard <= 1'b0;

         case (r_state)
            S_IDLE: begin
               // The guard masks the request still visible in the cycle right
               // after pmem_resp, so a slow-to-drop requester never re-triggers.
               if ((pmem_read || pmem_write) && !r_guard) begin
                  r_we        <= pmem_write;   // write wins if both are high
                  r_addr      <= pmem_address & LINE_MASK;
                  r_cmd_valid <= 1'b1;
                  if (pmem_write) begin
                     r_line <= pmem_wdata;
                  end
                  r_state <= S_CMD;
               end
            end

            S_CMD: begin
               if (mem_cmd_ready) begin
                  r_cmd_valid <= 1'b0;
                  r_cnt       <= '0;
                  if (r_we) begin
                     r_wvalid <= 1'b1;
                     r_wdata  <= r_line[0];
                     r_state  <= S_WBEAT;
                  end else begin
                     r_state  <= S_RBEAT;
                  end
               end
            end

            S_WBEAT: begin
               if (mem_wready) begin
                  r_cnt   <= w_cnt_nxt;
                  r_wdata <= r_line[w_cnt_nxt];
                  if (w_last) begin
                     r_wvalid <= 1'b0;
                     r_resp   <= 1'b1;
                     r_state  <= S_RESP;
                  end
               end
            end

            S_RBEAT: begin
               if (mem_rvalid) begin
                  r_line <= w_line_nxt;
                  r_cnt  <= w_cnt_nxt;
                  if (w_last) begin
                     r_rdata <= w_line_nxt;
                     r_resp  <= 1'b1;
                     r_state <= S_RESP;
                  end
               end
            end

            S_RESP: begin
               r_guard <= 1'b1;
               r_state <= S_IDLE;
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign pmem_resp     = r_resp;
   assign pmem_rdata    = r_rdata;
   assign mem_cmd_valid = r_cmd_valid;
   assign mem_cmd_we    = r_we;
   assign mem_cmd_addr  = r_addr;
   assign mem_wvalid    = r_wvalid;
   assign mem_wdata     = r_wdata;

endmodule

// File: tb/tb_pmem_line_bridge.sv
// ----------------------------------------------------------------------------
// tb_pmem_line_bridge
//
// Directed bench for pmem_line_bridge. The downstream memory is driven cycle
// by cycle from the stimulus sequence. Inputs change and outputs are sampled
// 1 time unit after each rising edge.
// ----------------------------------------------------------------------------
module tb_pmem_line_bridge;

   localparam int ADDR_W = 32;
   localparam int LINE_W = 256;
   localparam int BEAT_W = 64;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              pmem_read;
   logic              pmem_write;
   logic [ADDR_W-1:0] pmem_address;
   logic [LINE_W-1:0] pmem_wdata;
   logic              pmem_resp;
   logic [LINE_W-1:0] pmem_rdata;
   logic              mem_cmd_valid;
   logic              mem_cmd_ready;
   logic              mem_cmd_we;
   logic [ADDR_W-1:0] mem_cmd_addr;
   logic              mem_wvalid;
   logic              mem_wready;
   logic [BEAT_W-1:0] mem_wdata;
   logic              mem_rvalid;
   logic [BEAT_W-1:0] mem_rdata;

   int checks   = 0;
   int failures = 0;
   int cmd_count  = 0;
   int resp_count = 0;

   always #5 clk = ~clk;

   pmem_line_bridge #(
      .ADDR_W(ADDR_W),
      .LINE_W(LINE_W),
      .BEAT_W(BEAT_W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_address (pmem_address),
      .pmem_wdata   (pmem_wdata),
      .pmem_resp    (pmem_resp),
      .pmem_rdata   (pmem_rdata),
      .mem_cmd_valid(mem_cmd_valid),
      .mem_cmd_ready(mem_cmd_ready),
      .mem_cmd_we   (mem_cmd_we),
      .mem_cmd_addr (mem_cmd_addr),
      .mem_wvalid   (mem_wvalid),
      .mem_wready   (mem_wready),
      .mem_wdata    (mem_wdata),
      .mem_rvalid   (mem_rvalid),
      .mem_rdata    (mem_rdata)
   );

   // Counts accepted commands and completion pulses.
   always @(posedge clk) begin
      if (mem_cmd_valid && mem_cmd_ready) cmd_count <= cmd_count + 1;
      if (pmem_resp) resp_count <= resp_count + 1;
   end

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_vec(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drives four read beats starting in the first RBEAT cycle; returns at the
   // start of the cycle in which pmem_resp is due.
   task automatic read_beats(input logic [63:0] b0, input logic [63:0] b1,
                             input logic [63:0] b2, input logic [63:0] b3);
      mem_rvalid = 1'b1;
      mem_rdata  = b0;
      cyc();
      mem_rdata  = b1;
      cyc();
      mem_rdata  = b2;
      cyc();
      mem_rdata  = b3;
      chk_bit("resp_not_early", pmem_resp, 1'b0);
      cyc();
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
   endtask

   localparam logic [255:0] LINE_RD1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                        64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
   localparam logic [255:0] LINE_WR2 = {64'd3, 64'd2, 64'd1, 64'd0};
   localparam logic [255:0] LINE_RD3 = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                        64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
   localparam logic [255:0] LINE_RD4 = {64'h8888_0000_8888_0000, 64'h7777_0000_7777_0000,
                                        64'h6666_0000_6666_0000, 64'h5555_0000_5555_0000};
   localparam logic [255:0] LINE_RD6 = {64'h5678_5678_5678_5678, 64'h1234_1234_1234_1234,
                                        64'hFFFF_FFFF_FFFF_FFFF, 64'hEEEE_EEEE_EEEE_EEEE};

   int n_cmd;
   int n_resp;

   initial begin
      rst_n         = 1'b0;
      pmem_read     = 1'b0;
      pmem_write    = 1'b0;
      pmem_address  = '0;
      pmem_wdata    = '0;
      mem_cmd_ready = 1'b0;
      mem_wready    = 1'b0;
      mem_rvalid    = 1'b0;
      mem_rdata     = '0;

      // ---- reset state ----
      cyc(2);
      chk_vec("reset_ctrl", 256'({pmem_resp, mem_cmd_valid, mem_cmd_we, mem_wvalid}), 256'(0));
      chk_vec("reset_addr", 256'(mem_cmd_addr), 256'(0));
      chk_vec("reset_wdata", 256'(mem_wdata), 256'(0));
      chk_vec("reset_rdata", pmem_rdata, 256'(0));
      rst_n = 1'b1;
      cyc();

      // ---- read, zero-wait downstream ----
      pmem_read     = 1'b1;
      pmem_address  = 32'h0000_1234;
      mem_cmd_ready = 1'b1;
      cyc();                                  // cycle 2: CMD
      chk_bit("rd1_cmd_valid", mem_cmd_valid, 1'b1);
      chk_vec("rd1_cmd_addr", 256'(mem_cmd_addr), 256'(32'h0000_1220));
      chk_bit("rd1_cmd_we", mem_cmd_we, 1'b0);
      cyc();                                  // cycle 3: first beat
      chk_bit("rd1_cmd_dropped", mem_cmd_valid, 1'b0);
      read_beats(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                 64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);
      chk_bit("rd1_resp_c7", pmem_resp, 1'b1);
      chk_vec("rd1_rdata", pmem_rdata, LINE_RD1);
      pmem_read = 1'b0;
      cyc();
      chk_bit("rd1_resp_one_cycle", pmem_resp, 1'b0);
      chk_vec("rd1_rdata_hold", pmem_rdata, LINE_RD1);
      cyc();

      // ---- write with 2-cycle stall on beat 2 ----
      pmem_write    = 1'b1;
      pmem_address  = 32'h8000_00FF;
      pmem_wdata    = LINE_WR2;
      mem_wready    = 1'b1;
      cyc();                                  // cycle 2: CMD
      pmem_wdata    = {4{64'hBAD0_BAD0_BAD0_BAD0}};   // must not be used
      chk_bit("wr2_cmd_valid", mem_cmd_valid, 1'b1);
      chk_vec("wr2_cmd_addr", 256'(mem_cmd_addr), 256'(32'h8000_00E0));
      chk_bit("wr2_cmd_we", mem_cmd_we, 1'b1);
      chk_bit("wr2_no_beat_in_cmd", mem_wvalid, 1'b0);
      cyc();                                  // cycle 3
      chk_bit("wr2_wvalid", mem_wvalid, 1'b1);
      chk_vec("wr2_beat0", 256'(mem_wdata), 256'(64'd0));
      cyc();                                  // cycle 4
      chk_vec("wr2_beat1", 256'(mem_wdata), 256'(64'd1));
      cyc();                                  // cycle 5
      chk_vec("wr2_beat2", 256'(mem_wdata), 256'(64'd2));
      mem_wready = 1'b0;
      cyc();                                  // cycle 6: stall
      chk_bit("wr2_stall1_wvalid", mem_wvalid, 1'b1);
      chk_vec("wr2_stall1_beat2", 256'(mem_wdata), 256'(64'd2));
      cyc();                                  // cycle 7: stall
      chk_vec("wr2_stall2_beat2", 256'(mem_wdata), 256'(64'd2));
      mem_wready = 1'b1;
      cyc();                                  // cycle 8
      chk_vec("wr2_beat3", 256'(mem_wdata), 256'(64'd3));
      chk_bit("wr2_resp_not_early", pmem_resp, 1'b0);
      cyc();                                  // cycle 9
      chk_bit("wr2_resp_c9", pmem_resp, 1'b1);
      chk_bit("wr2_wvalid_done", mem_wvalid, 1'b0);
      chk_vec("wr2_rdata_untouched", pmem_rdata, LINE_RD1);
      pmem_write = 1'b0;
      cyc(2);

      // ---- command backpressure (5 cycles) + held request / guard ----
      n_cmd         = cmd_count;
      pmem_read     = 1'b1;
      pmem_address  = 32'h0000_405F;
      mem_cmd_ready = 1'b0;
      cyc();                                  // cycle 2: CMD, stalled
      mem_rvalid = 1'b1;                      // stray beats while not bursting
      mem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
      chk_bit("bp_cmd_valid", mem_cmd_valid, 1'b1);
      chk_vec("bp_cmd_addr", 256'(mem_cmd_addr), 256'(32'h0000_4040));
      cyc(4);                                 // cycle 6: still stalled
      chk_bit("bp_cmd_valid_hold", mem_cmd_valid, 1'b1);
      chk_vec("bp_cmd_addr_hold", 256'(mem_cmd_addr), 256'(32'h0000_4040));
      chk_bit("bp_no_wbeat", mem_wvalid, 1'b0);
      cyc();                                  // cycle 7: accept
      mem_cmd_ready = 1'b1;
      mem_rvalid    = 1'b0;
      chk_bit("bp_cmd_valid_c7", mem_cmd_valid, 1'b1);
      cyc();                                  // cycle 8: first beat
      read_beats(64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
                 64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD);
      chk_bit("bp_resp_c12", pmem_resp, 1'b1);
      chk_vec("bp_rdata", pmem_rdata, LINE_RD3);
      cyc();                                  // requester still holds read
      chk_bit("guard_resp_low", pmem_resp, 1'b0);
      pmem_read = 1'b0;
      cyc();
      chk_bit("guard_no_recmd", mem_cmd_valid, 1'b0);
      chk_vec("guard_cmd_count", 256'(cmd_count), 256'(n_cmd + 1));
      cyc();

      // ---- back-to-back read then write, one idle cycle between ----
      n_cmd        = cmd_count;
      n_resp       = resp_count;
      pmem_read    = 1'b1;
      pmem_address = 32'h0000_2000;
      cyc(2);                                 // cycle 3
      read_beats(64'h5555_0000_5555_0000, 64'h6666_0000_6666_0000,
                 64'h7777_0000_7777_0000, 64'h8888_0000_8888_0000);
      chk_bit("b2b_rd_resp", pmem_resp, 1'b1);
      chk_vec("b2b_rd_rdata", pmem_rdata, LINE_RD4);
      pmem_read = 1'b0;
      cyc();                                  // idle (guard) cycle
      cyc();
      pmem_write   = 1'b1;
      pmem_address = 32'h0000_2040;
      pmem_wdata   = {4{64'h0F0F_0F0F_0F0F_0F0F}};
      cyc();
      chk_bit("b2b_wr_cmd_we", mem_cmd_we, 1'b1);
      chk_vec("b2b_wr_cmd_addr", 256'(mem_cmd_addr), 256'(32'h0000_2040));
      cyc(5);
      chk_bit("b2b_wr_resp", pmem_resp, 1'b1);
      pmem_write = 1'b0;
      cyc();
      chk_vec("b2b_cmd_count", 256'(cmd_count), 256'(n_cmd + 2));
      chk_vec("b2b_resp_count", 256'(resp_count), 256'(n_resp + 2));
      cyc();

      // ---- simultaneous read + write ----
      n_cmd        = cmd_count;
      n_resp       = resp_count;
      pmem_read    = 1'b1;
      pmem_write   = 1'b1;
      pmem_address = 32'h0000_0100;
      pmem_wdata   = {64'hC3, 64'hC2, 64'hC1, 64'hC0};
      cyc();
      chk_bit("rw_cmd_we", mem_cmd_we, 1'b1);
      cyc();
      chk_bit("rw_wvalid", mem_wvalid, 1'b1);
      chk_vec("rw_beat0", 256'(mem_wdata), 256'(64'hC0));
      cyc(4);
      chk_bit("rw_resp", pmem_resp, 1'b1);
      chk_vec("rw_rdata_unchanged", pmem_rdata, LINE_RD4);
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      cyc();
      chk_vec("rw_cmd_count", 256'(cmd_count), 256'(n_cmd + 1));
      chk_vec("rw_resp_count", 256'(resp_count), 256'(n_resp + 1));
      cyc();

      // ---- reset mid-read after beat 1 ----
      pmem_read    = 1'b1;
      pmem_address = 32'h0000_3000;
      cyc(2);                                 // cycle 3: beat 0
      mem_rvalid = 1'b1;
      mem_rdata  = 64'h0101_0101_0101_0101;
      cyc();                                  // cycle 4: beat 1
      mem_rdata  = 64'h0202_0202_0202_0202;
      cyc();                                  // cycle 5
      pmem_read  = 1'b0;
      rst_n      = 1'b0;
      #1;
      chk_vec("rst_mid_ctrl", 256'({pmem_resp, mem_cmd_valid, mem_cmd_we, mem_wvalid}), 256'(0));
      chk_vec("rst_mid_addr", 256'(mem_cmd_addr), 256'(0));
      chk_vec("rst_mid_wdata", 256'(mem_wdata), 256'(0));
      chk_vec("rst_mid_rdata", pmem_rdata, 256'(0));
      cyc();
      rst_n     = 1'b1;
      mem_rdata = 64'h0303_0303_0303_0303;    // stray beats after reset
      cyc(2);
      chk_bit("rst_stray_no_resp", pmem_resp, 1'b0);
      chk_bit("rst_stray_no_cmd", mem_cmd_valid, 1'b0);
      chk_vec("rst_stray_rdata", pmem_rdata, 256'(0));
      mem_rvalid   = 1'b0;
      pmem_read    = 1'b1;
      pmem_address = 32'h0000_3000;
      cyc();
      chk_vec("rst_rd_cmd_addr", 256'(mem_cmd_addr), 256'(32'h0000_3000));
      cyc();
      read_beats(64'hEEEE_EEEE_EEEE_EEEE, 64'hFFFF_FFFF_FFFF_FFFF,
                 64'h1234_1234_1234_1234, 64'h5678_5678_5678_5678);
      chk_bit("rst_rd_resp_c7", pmem_resp, 1'b1);
      chk_vec("rst_rd_rdata", pmem_rdata, LINE_RD6);
      pmem_read = 1'b0;
      cyc(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
